// File: rtl/dmem_byte_bridge.sv
// rtl/dmem_byte_bridge.sv - 16-bit core data port to 8-bit req/ack memory bus bridge, big-endian.
// Optional MEM_TIMEOUT_EN aborts a beat after TIMEOUT_CYCLES without mem_ack.
module dmem_byte_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_mem_assert,
  input  logic        d_mem_cmd,
  input  logic [15:0] d_mem_addr,
  input  logic        d_mem_be0,
  input  logic        d_mem_be1,
  input  logic [15:0] d_mem_data_out,
  output logic [15:0] d_mem_data_in,
  output logic        d_mem_rdy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_q, word_q;
  logic [15:0] data_q, rd_q;
  logic        accept, timeout, abort_q;

  localparam bit CFG_OK = (TIMEOUT_CYCLES < (2 ** TO_W));
  generate
    if (!CFG_OK) begin : g_cfg_check
      $error("dmem_byte_bridge: TIMEOUT_CYCLES must fit in TO_W bits");
    end
  endgenerate

  // The request is still held during the rdy cycle; ignoring it there avoids replaying it.
  assign accept = d_mem_assert && !d_mem_rdy;

`ifdef MEM_TIMEOUT_EN
  logic            in_beat;
  logic [TO_W-1:0] to_cnt;

  assign in_beat = (state_q == BEAT0) || (state_q == BEAT1);
  assign timeout = in_beat && !mem_ack && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      abort_q <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      to_cnt  <= (in_beat && !mem_ack) ? to_cnt + 1'b1 : '0;
      bus_err <= (state_q == DONE) && abort_q;
      if (timeout)
        abort_q <= 1'b1;
      else if (state_q == DONE)
        abort_q <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
  assign abort_q = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = BEAT0;
      BEAT0: begin
        if (mem_ack)      state_d = word_q ? BEAT1 : DONE;
        else if (timeout) state_d = DONE;
      end
      BEAT1: if (mem_ack || timeout) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_q         <= 1'b0;
      word_q        <= 1'b0;
      data_q        <= 16'h0000;
      rd_q          <= 16'h0000;
      d_mem_rdy     <= 1'b0;
      d_mem_data_in <= 16'h0000;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 16'h0000;
      mem_wdata     <= 8'h00;
    end else begin
      state_q       <= state_d;
      d_mem_rdy     <= (state_q == DONE);
      d_mem_data_in <= 16'h0000;
      case (state_q)
        IDLE: begin
          if (accept) begin
            cmd_q   <= d_mem_cmd;
            word_q  <= d_mem_be0 & d_mem_be1;
            data_q  <= d_mem_data_out;
            rd_q    <= 16'h0000;
            mem_req <= 1'b1;
            mem_we  <= d_mem_cmd;
            if (d_mem_be0 & d_mem_be1) begin
              mem_addr  <= {d_mem_addr[15:1], 1'b0};
              mem_wdata <= d_mem_data_out[15:8];
            end else begin
              mem_addr  <= d_mem_addr;
              mem_wdata <= d_mem_data_out[7:0];
            end
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            // Word: keep mem_req high and load the odd beat on the same edge.
            if (word_q) begin
              rd_q[15:8] <= mem_rdata;
              mem_addr   <= {mem_addr[15:1], 1'b1};
              mem_wdata  <= data_q[7:0];
            end else begin
              rd_q[7:0] <= mem_rdata;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
            end
          end else if (timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        BEAT1: begin
          if (mem_ack) begin
            rd_q[7:0] <= mem_rdata;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
          end else if (timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        DONE: begin
          if (abort_q)
            d_mem_data_in <= 16'hFFFF;
          else if (!cmd_q)
            d_mem_data_in <= rd_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_byte_bridge.sv
// tb/tb_dmem_byte_bridge.sv - randomized self-checking bench for dmem_byte_bridge against a byte-memory model.
module tb_dmem_byte_bridge;

`ifdef MEM_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        d_mem_assert, d_mem_cmd, d_mem_be0, d_mem_be1;
  logic [15:0] d_mem_addr, d_mem_data_out, d_mem_data_in;
  logic        d_mem_rdy, mem_req, mem_we, mem_ack, bus_err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem [0:65535];
  int          checks = 0;
  int          failures = 0;

  int          wmin = 0, wmax = 0;
  bit          ack_off = 1'b0, noise = 1'b0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  dmem_byte_bridge #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .d_mem_assert(d_mem_assert), .d_mem_cmd(d_mem_cmd), .d_mem_addr(d_mem_addr),
    .d_mem_be0(d_mem_be0), .d_mem_be1(d_mem_be1), .d_mem_data_out(d_mem_data_out),
    .d_mem_data_in(d_mem_data_in), .d_mem_rdy(d_mem_rdy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  // Memory responder: each beat withholds ack for a random number of cycles in [wmin,wmax].
  initial begin
    int  rcnt, rwait;
    bit  fire;
    mem_ack = 1'b0;
    rcnt = 0;
    rwait = 0;
    forever begin
      @(negedge clk);
      fire = mem_req && mem_ack;
      @(posedge clk);
      #1;
      if (fire || !mem_req) begin
        rcnt  = 0;
        rwait = int'($urandom_range(wmax, wmin));
      end
      if (rst)
        mem_ack = 1'b0;
      else if (!mem_req)
        mem_ack = noise ? ($urandom_range(1, 0) == 1) : 1'b0;
      else if (!ack_off && rcnt >= rwait)
        mem_ack = 1'b1;
      else begin
        mem_ack = 1'b0;
        rcnt++;
      end
    end
  end

  task automatic run_txn(input string nm, input logic cmd, input logic [15:0] addr,
                         input logic be0, input logic be1, input logic [15:0] wd, output int lat);
    logic        word;
    logic [15:0] base, exp_rd;
    logic [15:0] ea [2];
    logic [7:0]  ed [2];
    int          en, waits, nchk;
    logic [15:0] ba [$];
    logic [7:0]  bd [$];
    logic        bw [$];
    logic        p_req, p_ack;
    logic [24:0] p_bus;
    bit          done;
    word  = be0 & be1;
    base  = word ? {addr[15:1], 1'b0} : addr;
    en    = word ? 2 : 1;
    ea[0] = base;
    ed[0] = word ? wd[15:8] : wd[7:0];
    ea[1] = {base[15:1], 1'b1};
    ed[1] = wd[7:0];
    exp_rd = cmd ? 16'h0000 : (word ? {mem[ea[0]], mem[ea[1]]} : {8'h00, mem[addr]});
    d_mem_cmd = cmd; d_mem_addr = addr; d_mem_be0 = be0; d_mem_be1 = be1;
    d_mem_data_out = wd; d_mem_assert = 1'b1;
    lat = 0; waits = 0; p_req = 1'b0; p_ack = 1'b0; p_bus = '0; done = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      if (d_mem_rdy) done = 1'b1;
      else begin
        if (p_req && !p_ack) begin
          checks++;
          if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, p_bus}) begin
            failures++;
            $display("FAIL %s stable_wait: got req/we/addr/wdata=%0b/%0b/%h/%h want 1/%0b/%h/%h",
                     nm, mem_req, mem_we, mem_addr, mem_wdata, p_bus[24], p_bus[23:8], p_bus[7:0]);
          end
        end
        if (mem_req && !mem_ack) waits++;
        if (mem_req && mem_ack) begin
          ba.push_back(mem_addr); bd.push_back(mem_wdata); bw.push_back(mem_we);
          if (mem_we) mem[mem_addr] = mem_wdata;
        end
        p_req = mem_req; p_ack = mem_ack; p_bus = {mem_we, mem_addr, mem_wdata};
        lat++;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s rdy_timeout: no d_mem_rdy within %0d cycles", nm, lat);
    end else begin
      checks++;
      if (lat != (word ? 4 : 3) + waits) begin
        failures++;
        $display("FAIL %s latency: got %0d want %0d", nm, lat, (word ? 4 : 3) + waits);
      end
      checks++;
      if (d_mem_data_in !== exp_rd) begin
        failures++;
        $display("FAIL %s data_in: got %h want %h", nm, d_mem_data_in, exp_rd);
      end
      checks++;
      if (bus_err !== 1'b0) begin
        failures++;
        $display("FAIL %s bus_err: got %b want 0", nm, bus_err);
      end
      checks++;
      if (ba.size() != en) begin
        failures++;
        $display("FAIL %s beat_count: got %0d want %0d", nm, ba.size(), en);
      end
      nchk = (ba.size() < en) ? ba.size() : en;
      for (int i = 0; i < nchk; i++) begin
        checks++;
        if (ba[i] !== ea[i] || bw[i] !== cmd || (cmd && bd[i] !== ed[i])) begin
          failures++;
          $display("FAIL %s beat%0d: got addr/we/wdata=%h/%b/%h want %h/%b/%h",
                   nm, i, ba[i], bw[i], bd[i], ea[i], cmd, ed[i]);
        end
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if ({d_mem_rdy, mem_req} !== 2'b00) begin
      failures++;
      $display("FAIL %s after_rdy: got rdy/req=%b/%b want 0/0", nm, d_mem_rdy, mem_req);
    end
    d_mem_assert = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    d_mem_assert = 1'b1; d_mem_cmd = 1'b1; d_mem_addr = 16'h1234;
    d_mem_be0 = 1'b1; d_mem_be1 = 1'b1; d_mem_data_out = 16'hBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({d_mem_rdy, d_mem_data_in, mem_req, mem_we, mem_addr, mem_wdata, bus_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b din=%h req=%b we=%b addr=%h wd=%h err=%b want all 0",
               d_mem_rdy, d_mem_data_in, mem_req, mem_we, mem_addr, mem_wdata, bus_err);
    end
    d_mem_assert = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got mem_req=%b want 0", mem_req);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_byte_read;
    int lat;
    wmin = 0; wmax = 0;
    mem[16'h1234] = 8'h5A;
    run_txn("byte_read", 1'b0, 16'h1234, 1'b0, 1'b1, 16'hFFFF, lat);
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL byte_read_lat: got %0d want 3", lat);
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_word_write;
    int lat;
    wmin = 0; wmax = 0;
    run_txn("word_write", 1'b1, 16'hB003, 1'b1, 1'b1, 16'hC0DE, lat);
    checks++;
    if (lat != 4 || mem[16'hB002] !== 8'hC0 || mem[16'hB003] !== 8'hDE) begin
      failures++;
      $display("FAIL word_write_result: got lat=%0d mem=%h%h want 4 c0de", lat, mem[16'hB002], mem[16'hB003]);
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_word_read_waits;
    int lat;
    wmin = 2; wmax = 2;
    mem[16'hC000] = 8'h12; mem[16'hC001] = 8'h34;
    run_txn("word_read_wait", 1'b0, 16'hC001, 1'b1, 1'b1, 16'h0000, lat);
    checks++;
    if (lat != 8) begin
      failures++;
      $display("FAIL word_read_wait_lat: got %0d want 8", lat);
    end
    wmin = 0; wmax = 0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_back_to_back;
    int lat;
    wmin = 0; wmax = 1;
    run_txn("b2b_write", 1'b1, 16'h3001, 1'b0, 1'b0, 16'h1177, lat);
    run_txn("b2b_read", 1'b0, 16'h3001, 1'b1, 1'b1, 16'h0000, lat);
    checks++;
    if (mem[16'h3001] !== 8'h77) begin
      failures++;
      $display("FAIL b2b_mem: got %h want 77", mem[16'h3001]);
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset_mid_op;
    int  lat, n;
    bit  in_b1, beat0_seen, rdy_seen;
    logic [7:0] odd_old;
    wmin = 3; wmax = 3;
    odd_old = mem[16'h4001];
    d_mem_cmd = 1'b1; d_mem_addr = 16'h4000; d_mem_be0 = 1'b1; d_mem_be1 = 1'b1;
    d_mem_data_out = 16'hA55A; d_mem_assert = 1'b1;
    in_b1 = 1'b0; beat0_seen = 1'b0; n = 0;
    while (!in_b1 && n < 50) begin
      @(negedge clk);
      if (mem_req && mem_ack) begin
        beat0_seen = 1'b1;
        mem[mem_addr] = mem_wdata;
      end
      if (mem_req && mem_addr[0]) in_b1 = 1'b1;
      n++;
    end
    checks++;
    if (!in_b1 || !beat0_seen) begin
      failures++;
      $display("FAIL rst_mid_reach_beat1: got beat1=%b beat0_done=%b want 1/1", in_b1, beat0_seen);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req, d_mem_rdy} !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_drop: got req/rdy=%b/%b want 0/0", mem_req, d_mem_rdy);
    end
    rst = 1'b0; d_mem_assert = 1'b0;
    rdy_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (d_mem_rdy || mem_req) rdy_seen = 1'b1;
    end
    checks++;
    if (rdy_seen || mem[16'h4000] !== 8'hA5 || mem[16'h4001] !== odd_old) begin
      failures++;
      $display("FAIL rst_mid_after: got activity=%b mem=%h%h want 0 a5%h",
               rdy_seen, mem[16'h4000], mem[16'h4001], odd_old);
    end
    @(posedge clk);
    #1;
    wmin = 0; wmax = 0;
    run_txn("rst_mid_next", 1'b0, 16'h4000, 1'b1, 1'b0, 16'h0000, lat);
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL rst_mid_next_lat: got %0d want 3", lat);
    end
  endtask

  task automatic test_random;
    int lat, gap;
    wmin = 0; wmax = 3; noise = 1'b1;
    for (int i = 0; i < 40; i++) begin
      run_txn("random", 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), lat);
      gap = int'($urandom_range(2, 0));
      repeat (gap) begin @(posedge clk); #1; end
    end
    noise = 1'b0; wmin = 0; wmax = 0;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    int lat, reqc, tmp;
    bit done;
    ack_off = 1'b1;
    d_mem_cmd = 1'b0; d_mem_addr = 16'h5555; d_mem_be0 = 1'b0; d_mem_be1 = 1'b1;
    d_mem_data_out = 16'h0000; d_mem_assert = 1'b1;
    lat = 0; reqc = 0; done = 1'b0;
    while (!done && lat < 100) begin
      @(negedge clk);
      if (d_mem_rdy) done = 1'b1;
      else begin
        if (mem_req) reqc++;
        lat++;
      end
    end
    checks++;
    if (!done || lat != 2 + TO_CYC || reqc != TO_CYC) begin
      failures++;
      $display("FAIL timeout_timing: got done=%b lat=%0d req_cycles=%0d want 1 %0d %0d",
               done, lat, reqc, 2 + TO_CYC, TO_CYC);
    end
    checks++;
    if (bus_err !== 1'b1 || d_mem_data_in !== 16'hFFFF) begin
      failures++;
      $display("FAIL timeout_abort: got bus_err=%b data=%h want 1 ffff", bus_err, d_mem_data_in);
    end
    @(posedge clk);
    #1;
    d_mem_assert = 1'b0;
    ack_off = 1'b0;
    checks++;
    if (bus_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err_pulse: got %b want 0", bus_err);
    end
    @(posedge clk);
    #1;
    run_txn("after_timeout", 1'b0, 16'h5555, 1'b0, 1'b1, 16'h0000, tmp);
  endtask
`endif

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_byte_read();
    test_word_write();
    test_word_read_waits();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
